demux_four_stream: RTL

- Registered 1-to-4 stream demultiplexer; the distribution-side counterpart of the 4:1 selector tree.
- Accepts one data word per cycle on a valid/ready input, routes it by a 2-bit select to one of four output channels, and holds it in a per-channel output register until the consumer takes it.
- Keeps a per-channel delivered-word counter for debug and test observation.

---
 rtl/demux_four_stream_pkg.sv | 17 +
 rtl/demux_slot.sv | 59 +++++
 rtl/demux_four_stream.sv | 63 ++++++
 3 files changed

// File: rtl/demux_four_stream_pkg.sv
//------------------------------------------------------------------------------
// Module      : demux_four_stream_pkg
// Description : Shared channel count, select width and channel-index type.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package demux_four_stream_pkg;

    localparam int NUM_OUT = 4;
    localparam int SEL_W   = 2;

    typedef logic [SEL_W-1:0] chan_idx_t;

endpackage

`default_nettype wire

// File: rtl/demux_slot.sv
//------------------------------------------------------------------------------
// Module      : demux_slot
// Description : One output register stage with valid/ready and a wrapping
//               delivered-word counter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module demux_slot
    import demux_four_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count,
    output logic             slot_ready
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_count;
    logic             w_drain;

    assign w_drain    = r_valid && out_ready;
    assign slot_ready = !r_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_count <= '0;
        end else begin
            // A load in the same cycle as a drain keeps the slot full.
            if (load) begin
                r_valid <= 1'b1;
                r_data  <= load_data;
            end else if (w_drain) begin
                r_valid <= 1'b0;
            end
            if (w_drain) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign count     = r_count;

endmodule

`default_nettype wire

// File: rtl/demux_four_stream.sv
//------------------------------------------------------------------------------
// Module      : demux_four_stream
// Description : Registered 1-to-4 stream demultiplexer with per-channel
//               output registers and delivered-word counters.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module demux_four_stream
    import demux_four_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  chan_idx_t                in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NUM_OUT*WIDTH-1:0] out_data,
    output logic [NUM_OUT-1:0]       out_valid,
    input  logic [NUM_OUT-1:0]       out_ready,
    output logic [NUM_OUT*CNT_W-1:0] out_count
);

    logic [NUM_OUT-1:0] w_slot_ready;
    logic [NUM_OUT-1:0] w_load;
    logic               w_accept;

    // Readiness depends only on the addressed slot, never on in_valid.
    assign in_ready = !rst && w_slot_ready[in_sel];
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_load = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            w_load[i] = w_accept && (in_sel == SEL_W'(i));
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_slot
            demux_slot #(
                .WIDTH (WIDTH),
                .CNT_W (CNT_W)
            ) u_slot (
                .clk        (clk),
                .rst        (rst),
                .load       (w_load[gi]),
                .load_data  (in_data),
                .out_ready  (out_ready[gi]),
                .out_valid  (out_valid[gi]),
                .out_data   (out_data[gi*WIDTH +: WIDTH]),
                .count      (out_count[gi*CNT_W +: CNT_W]),
                .slot_ready (w_slot_ready[gi])
            );
        end
    endgenerate

endmodule

`default_nettype wire
